// File: rtl/fifo_pkg.sv
// Shared constants for the synchronous FIFO slice: default geometry and
// the encodings of the read-mode parameter.
package fifo_pkg;

    localparam int DEFAULT_DATA_SIZE = 8;
    localparam int DEFAULT_ADDR_SIZE = 4;

    // Read-mode encodings for the FWFT parameter.
    localparam int FWFT_REGISTERED   = 0;  // rdata loaded on an accepted read
    localparam int FWFT_FALL_THROUGH = 1;  // head entry always visible on rdata

endpackage : fifo_pkg

// File: rtl/fifo_ram_sync.sv
// Storage array for sync_fifo: one write port clocked by wclk and one
// asynchronous read address, so the parent decides whether to register
// the read data or present it directly.
module fifo_ram_sync
    import fifo_pkg::*;
#(
    parameter int DATA_SIZE = DEFAULT_DATA_SIZE,
    parameter int ADDR_SIZE = DEFAULT_ADDR_SIZE
) (
    input  logic                 wclk,
    input  logic                 we,
    input  logic [ADDR_SIZE-1:0] waddr,
    input  logic [DATA_SIZE-1:0] wdata,
    input  logic [ADDR_SIZE-1:0] raddr,
    output logic [DATA_SIZE-1:0] rdata
);

    localparam int DEPTH = 1 << ADDR_SIZE;

    logic [DATA_SIZE-1:0] mem [DEPTH];

    // Store the write data on every enabled edge.
    // NOTE: the array has no reset; occupancy is tracked by the pointers, so
    // stale contents are never observable and the array can map onto RAM.
    always_ff @(posedge wclk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule : fifo_ram_sync

// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers, occupancy count, almost flags,
// sticky overflow/underflow errors and a selectable read mode (registered
// or first-word-fall-through).
module sync_fifo
    import fifo_pkg::*;
#(
    parameter int DATA_SIZE = DEFAULT_DATA_SIZE,
    parameter int ADDR_SIZE = DEFAULT_ADDR_SIZE,
    parameter int FWFT      = FWFT_REGISTERED,
    parameter int AFULL_TH  = (1 << ADDR_SIZE) - 2,
    parameter int AEMPTY_TH = 2
) (
    input  logic                 wclk,
    input  logic                 wrst_n,
    input  logic                 winc,
    input  logic [DATA_SIZE-1:0] wdata,
    input  logic                 rinc,
    output logic [DATA_SIZE-1:0] rdata,
    output logic                 rvalid,
    output logic                 wfull,
    output logic                 rempty,
    output logic                 almost_full,
    output logic                 almost_empty,
    output logic [ADDR_SIZE:0]   count,
    output logic                 overflow,
    output logic                 underflow,
    input  logic                 clr_err
);

    localparam int DEPTH = 1 << ADDR_SIZE;

    // Thresholds must be reachable occupancies.
    if (AFULL_TH > DEPTH || AEMPTY_TH > DEPTH) begin : g_bad_threshold
        $error("sync_fifo: AFULL_TH/AEMPTY_TH exceed FIFO depth");
    end

    localparam logic [ADDR_SIZE:0] AFULL_CNT  = AFULL_TH[ADDR_SIZE:0];
    localparam logic [ADDR_SIZE:0] AEMPTY_CNT = AEMPTY_TH[ADDR_SIZE:0];

    logic [ADDR_SIZE:0]   wptr;
    logic [ADDR_SIZE:0]   rptr;
    logic                 wr_en;
    logic                 rd_en;
    logic [DATA_SIZE-1:0] ram_rdata;

    // Status is derived from the registered pointers only, so it has no lag.
    assign rempty       = (wptr == rptr);
    assign wfull        = (wptr[ADDR_SIZE-1:0] == rptr[ADDR_SIZE-1:0]) &&
                          (wptr[ADDR_SIZE] != rptr[ADDR_SIZE]);
    assign count        = wptr - rptr;
    assign almost_full  = (count >= AFULL_CNT);
    assign almost_empty = (count <= AEMPTY_CNT);

    // Requests are gated by the flags as they stand before the edge.
    assign wr_en = winc && !wfull;
    assign rd_en = rinc && !rempty;

    // Advance the pointers on accepted requests; the wrap bit rolls over freely.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (wr_en) begin
                wptr <= wptr + 1'b1;
            end
            if (rd_en) begin
                rptr <= rptr + 1'b1;
            end
        end
    end

    // Sticky error flags: a new error in the same cycle beats a clear.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (winc && wfull) begin
                overflow <= 1'b1;
            end else if (clr_err) begin
                overflow <= 1'b0;
            end
            if (rinc && rempty) begin
                underflow <= 1'b1;
            end else if (clr_err) begin
                underflow <= 1'b0;
            end
        end
    end

    fifo_ram_sync #(
        .DATA_SIZE (DATA_SIZE),
        .ADDR_SIZE (ADDR_SIZE)
    ) u_ram (
        .wclk  (wclk),
        .we    (wr_en),
        .waddr (wptr[ADDR_SIZE-1:0]),
        .wdata (wdata),
        .raddr (rptr[ADDR_SIZE-1:0]),
        .rdata (ram_rdata)
    );

    if (FWFT == FWFT_FALL_THROUGH) begin : g_fwft
        // Head entry is presented directly; it is valid whenever not empty.
        assign rdata  = ram_rdata;
        assign rvalid = !rempty;
    end else begin : g_registered
        logic [DATA_SIZE-1:0] rdata_q;
        logic                 rvalid_q;

        // Capture the head on an accepted read and hold it otherwise.
        always_ff @(posedge wclk or negedge wrst_n) begin
            if (!wrst_n) begin
                rdata_q  <= '0;
                rvalid_q <= 1'b0;
            end else begin
                rvalid_q <= rd_en;
                if (rd_en) begin
                    rdata_q <= ram_rdata;
                end
            end
        end

        assign rdata  = rdata_q;
        assign rvalid = rvalid_q;
    end

endmodule : sync_fifo

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo (default parameters, registered read).
// A queue models FIFO contents; data popped by accepted reads is pushed to a
// scoreboard and compared when the DUT raises rvalid.
module tb_sync_fifo;

    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic          wclk;
    logic          wrst_n;
    logic          winc;
    logic [DW-1:0] wdata;
    logic          rinc;
    logic [DW-1:0] rdata;
    logic          rvalid;
    logic          wfull;
    logic          rempty;
    logic          almost_full;
    logic          almost_empty;
    logic [AW:0]   count;
    logic          overflow;
    logic          underflow;
    logic          clr_err;

    sync_fifo dut (
        .wclk         (wclk),
        .wrst_n       (wrst_n),
        .winc         (winc),
        .wdata        (wdata),
        .rinc         (rinc),
        .rdata        (rdata),
        .rvalid       (rvalid),
        .wfull        (wfull),
        .rempty       (rempty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow),
        .clr_err      (clr_err)
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    int            n_checks = 0;
    int            n_fail   = 0;
    logic [DW-1:0] model_q [$];
    logic [DW-1:0] exp_q   [$];
    logic [DW-1:0] last_rdata = '0;
    logic          ovf_m = 1'b0;
    logic          unf_m = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Compare every status output against the model.
    task automatic check_status();
        int n;
        n = model_q.size();
        check("count",        count,        n);
        check("rempty",       rempty,       (n == 0));
        check("wfull",        wfull,        (n == DEPTH));
        check("almost_full",  almost_full,  (n >= DEPTH - 2));
        check("almost_empty", almost_empty, (n <= 2));
        check("overflow",     overflow,     ovf_m);
        check("underflow",    underflow,    unf_m);
    endtask

    // One clock of stimulus; called and returns at posedge + 1.
    task automatic cycle(input logic w, input logic [DW-1:0] d, input logic r, input logic c);
        logic full_m, empty_m, w_acc, r_acc;
        full_m  = (model_q.size() == DEPTH);
        empty_m = (model_q.size() == 0);
        w_acc   = w && !full_m;
        r_acc   = r && !empty_m;
        if (r_acc) exp_q.push_back(model_q.pop_front());
        if (w_acc) model_q.push_back(d);
        ovf_m = (w && full_m)  ? 1'b1 : (c ? 1'b0 : ovf_m);
        unf_m = (r && empty_m) ? 1'b1 : (c ? 1'b0 : unf_m);

        winc = w; wdata = d; rinc = r; clr_err = c;
        @(posedge wclk);
        #1;
        winc = 1'b0; rinc = 1'b0; clr_err = 1'b0; wdata = '0;

        check("rvalid", rvalid, r_acc);
        if (rvalid) begin
            if (exp_q.size() == 0) begin
                check("sb_underrun", exp_q.size(), 1);
            end else begin
                last_rdata = exp_q.pop_front();
                check("rdata", rdata, last_rdata);
            end
        end else begin
            check("rdata_hold", rdata, last_rdata);
        end
        check_status();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        wrst_n = 1'b0; winc = 1'b0; rinc = 1'b0; clr_err = 1'b0; wdata = '0;
        repeat (3) @(posedge wclk);
        #1;
        // Reset state
        check("rst_rvalid", rvalid, 0);
        check("rst_rdata",  rdata,  0);
        check_status();
        @(negedge wclk);
        wrst_n = 1'b1;
        @(posedge wclk);
        #1;

        // Fill 0x00..0x0F, then a write while full is dropped
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, DW'(i), 1'b0, 1'b0);
        cycle(1'b1, 8'hAA, 1'b0, 1'b0);

        // Drain: data must come back 0x00..0x0F, then underflow on empty read
        for (int i = 0; i < DEPTH; i++) cycle(1'b0, '0, 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b1);   // underflow set beats clear
        cycle(1'b0, '0, 1'b0, 1'b1);   // clear both errors

        // Simultaneous at full: head read, write dropped
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, DW'(8'h40 + i), 1'b0, 1'b0);
        cycle(1'b1, 8'hEE, 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b1);
        while (model_q.size() > 0) cycle(1'b0, '0, 1'b1, 1'b0);

        // Simultaneous at empty: write accepted, read rejected, no bypass
        cycle(1'b1, 8'h77, 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b1);

        // Wrap: occupancy 3, 40 interleaved write/read pairs
        for (int i = 0; i < 3; i++) cycle(1'b1, DW'(8'h80 + i), 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) cycle(1'b1, DW'(8'h90 + i), 1'b1, 1'b0);
        while (model_q.size() > 0) cycle(1'b0, '0, 1'b1, 1'b0);

        // Random mix exercising all flag transitions
        for (int i = 0; i < 120; i++) begin
            cycle(1'($urandom_range(0, 1)), DW'($urandom),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0));
        end
        while (model_q.size() > 0) cycle(1'b0, '0, 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b1);

        // Reset mid-operation with count 9 and rvalid high
        for (int i = 0; i < 10; i++) cycle(1'b1, DW'(8'hC0 + i), 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0);
        #2;
        wrst_n = 1'b0;
        #1;
        model_q.delete();
        exp_q.delete();
        ovf_m = 1'b0; unf_m = 1'b0; last_rdata = '0;
        check("mid_rst_rvalid", rvalid, 0);
        check("mid_rst_rdata",  rdata,  0);
        check_status();
        @(negedge wclk);
        wrst_n = 1'b1;
        @(posedge wclk);
        #1;
        cycle(1'b1, 8'h5A, 1'b0, 1'b0);
        cycle(1'b1, 8'hA5, 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b0);

        check("sb_leftover", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_sync_fifo

// File: doc/sync_fifo.md
SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 SHALL have parameter DATA_SIZE, default 8, data width in bits.
REQ-002 SHALL have parameter ADDR_SIZE, default 4, address width; depth = 2^ADDR_SIZE.
REQ-003 SHALL have parameter FWFT, default 0, read mode: 0 = registered read, 1 = first-word-fall-through.
REQ-004 SHALL have parameter AFULL_TH, default 2^ADDR_SIZE-2, almost-full threshold (entries).
REQ-005 SHALL have parameter AEMPTY_TH, default 2, almost-empty threshold (entries).
REQ-006 SHALL have one clock and an asynchronous, active-low reset, named as below.
REQ-007 Ports SHALL be:
- wclk  in  1  clock, all state on rising edge
- wrst_n  in  1  async active-low reset
- winc  in  1  write request
- wdata  in  DATA_SIZE  write data
- rinc  in  1  read request
- rdata  out  DATA_SIZE  read data
- rvalid  out  1  rdata holds valid read data
- wfull  out  1  FIFO full
- rempty  out  1  FIFO empty
- almost_full  out  1  count >= AFULL_TH
- almost_empty  out  1  count <= AEMPTY_TH
- count  out  ADDR_SIZE+1  current occupancy, 0..2^ADDR_SIZE
- overflow  out  1  sticky: write attempted while full
- underflow  out  1  sticky: read attempted while empty
- clr_err  in  1  synchronous clear of overflow/underflow

Function
REQ-008 Write and read pointers SHALL be ADDR_SIZE+1 bits; MSB is the wrap bit; RAM indexed by low ADDR_SIZE bits.
REQ-009 Write accepted iff winc && !wfull (wfull sampled before the edge); accepted write stores wdata at wptr and increments wptr.
REQ-010 Read accepted iff rinc && !rempty (rempty sampled before the edge); accepted read increments rptr.
REQ-011 Simultaneous winc and rinc, neither full nor empty: both accepted, count unchanged.
REQ-012 Simultaneous winc and rinc when full: read accepted, write rejected, overflow set.
REQ-013 Simultaneous winc and rinc when empty: write accepted, read rejected, underflow set; no same-cycle bypass.
REQ-014 rempty = (wptr == rptr); wfull = low bits equal and MSBs differ; count = wptr - rptr modulo 2^(ADDR_SIZE+1); all derived from registered pointers, zero lag.
REQ-015 almost_full and almost_empty SHALL be combinational comparisons of count against the thresholds.
REQ-016 FWFT=0: rdata registered; on accepted read rdata <= mem[rptr] and rvalid = 1 for exactly the next cycle; rdata holds its value otherwise.
REQ-017 FWFT=1: rdata = mem[rptr low bits] combinationally; rvalid = !rempty; accepted read advances to the next entry in the following cycle.
REQ-018 Pointer wrap from 2^(ADDR_SIZE+1)-1 to 0 SHALL be seamless; no data loss or flag glitch across wrap.
REQ-019 overflow set on winc && wfull; underflow set on rinc && rempty; clr_err clears both; set wins over clear in the same cycle.
REQ-020 Rejected requests SHALL not alter pointers, RAM contents or rdata.

Reset
REQ-021 wrst_n low SHALL immediately force: wptr=0, rptr=0, count=0, rempty=1, wfull=0, almost_empty=1, almost_full=(AFULL_TH==0), rvalid=0, rdata=0 (FWFT=0), overflow=0, underflow=0.
REQ-022 RAM contents SHALL not be reset; reset mid-operation discards all queued entries.
REQ-023 Reset deassertion SHALL take effect at the first wclk rising edge with wrst_n high.

Structure
REQ-024 Shared package fifo_pkg SHALL hold default DATA_SIZE/ADDR_SIZE constants and the FWFT mode encodings.
REQ-025 RAM SHALL be a sub-module fifo_ram_sync (one write port, one read address, write on wclk); pointer/flag/error logic SHALL reside in sync_fifo.
REQ-026 Elaboration SHALL reject AFULL_TH > 2^ADDR_SIZE or AEMPTY_TH > 2^ADDR_SIZE.

Verification
REQ-027 Fill: reset, 16 writes 0x00..0x0F (defaults) -> wfull=1 after 16th, count=16, almost_full from count 14.
REQ-028 Drain (FWFT=0): 16 reads from full -> rdata 0x00..0x0F each one cycle after rinc, rvalid pulses, rempty=1 after last.
REQ-029 Overflow/underflow: winc when full -> overflow=1, data unchanged; rinc when empty -> underflow=1; clr_err -> both 0.
REQ-030 Simultaneous at full: winc+rinc -> head read, write dropped, count 15, overflow=1; at empty: write accepted, count 1, underflow=1.
REQ-031 Wrap: 40 interleaved write/read pairs at occupancy 3 -> in-order data, count constant 3, no wfull/rempty glitches.
REQ-032 Reset mid-operation: wrst_n low with count=9 -> count=0, rempty=1, rvalid=0 asynchronously; next write/read returns new data.
